spi_reg_ctrl: RTL

Command sequencer between the byte-level SPI slave receiver and an on-chip 8-bit register bank. Decodes the first byte of each SSEL-framed message as a read/write command with a start address, then streams write data into the bank or prefetches read data for MISO. Addresses auto-increment across the frame. Replaces the hard-wired per-byte LED decode with a general register-access protocol.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_reg_ctrl_if.sv | 26 ++
 rtl/spi_reg_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI register sequencer
package spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  localparam int         CMD_READ_BIT      = 7;
  localparam logic [7:0] IDLE_FILL_DEFAULT = 8'hFF;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - byte stream and register bank signals of the sequencer
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              frame_start;
  logic              frame_end;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              tx_load;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (
    output frame_start, frame_end, rx_valid, rx_byte, reg_rdata,
    input  tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    input  frame_start, frame_end, rx_valid, rx_byte, reg_rdata,
    output tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - decodes SSEL-framed SPI bytes into register bank reads and writes
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] IDLE_FILL = IDLE_FILL_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  spi_reg_ctrl_if.slave bus,
  output logic         busy,
  output logic [7:0]   frame_count
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              rd_pending;
  logic              data_seen;
  logic [ADDR_W-1:0] start_addr;
  logic              data_byte;

  assign start_addr = bus.rx_byte[ADDR_W-1:0];
  assign data_byte  = bus.rx_valid && (state == WRITE || state == READ);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      rd_pending    <= 1'b0;
      data_seen     <= 1'b0;
      frame_count   <= 8'd0;
      bus.tx_byte   <= IDLE_FILL;
      bus.tx_load   <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= 8'd0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
    end else begin
      bus.tx_load <= 1'b0;
      bus.reg_we  <= 1'b0;
      bus.reg_re  <= 1'b0;
      rd_pending  <= 1'b0;

      // Read data arrives the cycle after reg_re; hand it to the MISO shifter.
      if (rd_pending) begin
        bus.tx_byte <= bus.reg_rdata;
        bus.tx_load <= 1'b1;
      end

      if (bus.rx_valid) begin
        case (state)
          CMD: begin
            if (bus.rx_byte[CMD_READ_BIT]) begin
              bus.reg_addr <= start_addr;
              bus.reg_re   <= 1'b1;
              rd_pending   <= 1'b1;
              addr         <= start_addr + 1'b1;
              state        <= READ;
            end else begin
              addr  <= start_addr;
              state <= WRITE;
            end
          end
          WRITE: begin
            bus.reg_addr  <= addr;
            bus.reg_wdata <= bus.rx_byte;
            bus.reg_we    <= 1'b1;
            addr          <= addr + 1'b1;
            data_seen     <= 1'b1;
          end
          READ: begin
            bus.reg_addr <= addr;
            bus.reg_re   <= 1'b1;
            rd_pending   <= 1'b1;
            addr         <= addr + 1'b1;
            data_seen    <= 1'b1;
          end
          default: ;
        endcase
      end

      // Frame boundaries override the state chosen by the byte handling above.
      if (bus.frame_end) begin
        if (data_seen || data_byte) frame_count <= frame_count + 8'd1;
        data_seen <= 1'b0;
        state     <= IDLE;
      end else if (bus.frame_start) begin
        data_seen   <= 1'b0;
        state       <= CMD;
        bus.tx_byte <= IDLE_FILL;
        bus.tx_load <= 1'b1;
      end
    end
  end

endmodule
